// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory: CPU vs program loader.
// Each grant holds the strobes for MEM_LAT cycles, then pulses the grantee's ack for one cycle.
module mem_bus_arbiter #(
    parameter int AW      = 6,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_adr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] adr_bus,
    output logic          rd_mem,
    output logic          wr_mem,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_owner;

    logic          grant_ldr;
    logic          sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wdata;

    // Loader wins when it is alone, or on a tie when the CPU had the previous grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_ldr = 1'b0;
        sel_we    = cpu_we;
        sel_adr   = cpu_adr;
        sel_wdata = cpu_wdata;
        if (ldr_req && (!cpu_req || !last_owner)) begin
            grant_ldr = 1'b1;
            sel_we    = ldr_we;
            sel_adr   = ldr_adr;
            sel_wdata = ldr_wdata;
        end
    end

    // NOTE: all state below is sequential and uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            adr_bus    <= '0;
            rd_mem     <= 1'b0;
            wr_mem     <= 1'b0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        owner      <= grant_ldr;
                        last_owner <= grant_ldr;
                        cnt        <= CNT_INIT;
                        adr_bus    <= sel_adr;
                        rd_mem     <= !sel_we;
                        wr_mem     <= sel_we;
                        mem_wdata  <= sel_we ? sel_wdata : '0;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Read data is valid during the last strobe cycle.
                        if (rd_mem) begin
                            if (owner) ldr_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        state     <= ACK;
                        adr_bus   <= '0;
                        rd_mem    <= 1'b0;
                        wr_mem    <= 1'b0;
                        mem_wdata <= '0;
                        cpu_ack   <= !owner;
                        ldr_ack   <= owner;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table of single transactions, scoreboard of
// expected grants checked at each ack, plus hand-written arbitration and reset sequences.
module tb_mem_bus_arbiter;

    localparam int AW      = 6;
    localparam int DW      = 8;
    localparam int MEM_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, ldr_req, ldr_we;
    logic [AW-1:0] cpu_adr, ldr_adr;
    logic [DW-1:0] cpu_wdata, ldr_wdata;
    logic          cpu_ack, ldr_ack;
    logic [DW-1:0] cpu_rdata, ldr_rdata;
    logic [AW-1:0] adr_bus;
    logic          rd_mem, wr_mem;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, owner;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adr(ldr_adr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Behavioural memory behind the arbitrated port.
    logic [DW-1:0] mem [64];
    assign mem_rdata = rd_mem ? mem[adr_bus] : 8'h00;
    always @(posedge clk) if (wr_mem) mem[adr_bus] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // data = write data for writes, expected owner rdata for reads.
    typedef struct {
        bit            who;
        bit            we;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        bit            who;
        bit            we;
        bit            pre;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_cpu;
        logic [DW-1:0] exp_ldr;
    } vec_t;

    exp_t exp_q[$];

    // Scoreboard monitor: invariants every cycle, transaction contents at each ack.
    int            strobe_cnt;
    logic          s_we, s_owner, prev_ack;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdata;

    always @(negedge clk) begin
        if (reset) begin
            strobe_cnt = 0;
            prev_ack   = 1'b0;
        end else begin
            check("strobe_exclusive", 32'(rd_mem & wr_mem), 32'd0);
            check("busy", 32'(busy), 32'(rd_mem | wr_mem | cpu_ack | ldr_ack));
            if (!rd_mem && !wr_mem)
                check("idle_bus", {18'd0, adr_bus, mem_wdata}, 32'd0);
            else begin
                strobe_cnt++;
                s_we    = wr_mem;
                s_adr   = adr_bus;
                s_wdata = mem_wdata;
                s_owner = owner;
            end
            if (cpu_ack || ldr_ack) begin
                exp_t e;
                check("ack_onehot", 32'(cpu_ack & ldr_ack), 32'd0);
                check("ack_width", 32'(prev_ack), 32'd0);
                if (exp_q.size() == 0) fail_now("unexpected_ack");
                else begin
                    e = exp_q.pop_front();
                    check("grant_who", 32'(ldr_ack), 32'(e.who));
                    check("owner", 32'(s_owner), 32'(e.who));
                    check("strobe_we", 32'(s_we), 32'(e.we));
                    check("strobe_adr", 32'(s_adr), 32'(e.adr));
                    check("strobe_len", strobe_cnt, MEM_LAT);
                    if (e.we) check("strobe_wdata", 32'(s_wdata), 32'(e.data));
                    else      check("ack_rdata", 32'(e.who ? ldr_rdata : cpu_rdata), 32'(e.data));
                end
                strobe_cnt = 0;
            end
            prev_ack = cpu_ack | ldr_ack;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acks"}, {30'd0, cpu_ack, ldr_ack}, 32'd0);
        check({tag, "_rdata"}, {16'd0, cpu_rdata, ldr_rdata}, 32'd0);
        check({tag, "_bus"}, {16'd0, adr_bus, rd_mem, wr_mem, mem_wdata}, 32'd0);
        check({tag, "_busy_owner"}, {30'd0, busy, owner}, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input bit drop_early);
        exp_t e;
        bit   got;
        int   n;
        if (!v.we && v.pre) mem[v.adr] = v.data;
        e.who = v.who; e.we = v.we; e.adr = v.adr; e.data = v.data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (v.who) begin ldr_req = 1'b1; ldr_we = v.we; ldr_adr = v.adr; ldr_wdata = v.data; end
        else       begin cpu_req = 1'b1; cpu_we = v.we; cpu_adr = v.adr; cpu_wdata = v.data; end
        @(posedge clk);
        if (drop_early) begin #1; cpu_req = 1'b0; ldr_req = 1'b0; end
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = v.who ? ldr_ack : cpu_ack;
        end
        if (!got) fail_now("ack_timeout");
        else      check("ack_latency", n, MEM_LAT + 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        check("cpu_rdata", 32'(cpu_rdata), 32'(v.exp_cpu));
        check("ldr_rdata", 32'(ldr_rdata), 32'(v.exp_ldr));
        if (v.we) check("mem_written", 32'(mem[v.adr]), 32'(v.data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t v6;
        int   acks, cyc;

        //            who  we   pre  adr    data   exp_cpu exp_ldr
        vecs[0] = '{1'b0, 1'b0, 1'b1, 6'h15, 8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 6'h3F, 8'h5C, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 6'h3F, 8'h5C, 8'hA5, 8'h5C};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 6'h00, 8'hFF, 8'hA5, 8'h5C};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 6'h2A, 8'h3C, 8'hA5, 8'h3C};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'hFF, 8'hFF, 8'h3C};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 6'h2A, 8'h81, 8'hFF, 8'h3C};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 6'h2A, 8'h81, 8'hFF, 8'h81};

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_adr = '0; ldr_wdata = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], 1'b0);

        // Reset mid-sim while idle, with owner and rdata registers non-zero.
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midsim");
        @(posedge clk); #1;
        reset = 1'b0;

        // Both requesting continuously from reset: CPU, loader, CPU, loader.
        mem[6'h01] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{1'b0, 1'b0, 6'h01, 8'h11});
            exp_q.push_back('{1'b1, 1'b1, 6'h02, 8'h66});
        end
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 6'h01; cpu_wdata = 8'h00;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_adr = 6'h02; ldr_wdata = 8'h66;
        acks = 0;
        cyc  = 0;
        while (acks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack || ldr_ack) acks++;
        end
        if (acks < 4) fail_now("rr_timeout");
        @(posedge clk); #1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        check("rr_queue_drained", exp_q.size(), 0);
        check("rr_rdata", {16'd0, cpu_rdata, ldr_rdata}, {16'd0, 8'h11, 8'h00});

        // Request withdrawn one cycle into a read: transaction still completes.
        v6 = '{1'b0, 1'b0, 1'b1, 6'h10, 8'h42, 8'h42, 8'h00};
        run_txn(v6, 1'b1);

        // Reset during the first strobe cycle of a CPU read.
        mem[6'h20] = 8'h99;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 6'h20;
        @(posedge clk); #2;
        check("pre_reset_rd_mem", 32'(rd_mem), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_rd", {29'd0, rd_mem, wr_mem, busy}, 32'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("no_ack_after_reset", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        end
        check("lost_txn_state", {16'd0, cpu_rdata, 6'd0, busy, owner}, 32'd0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
